// File: rtl/axis_iic_pkg.sv
// Shared definitions for the I2C manager and its request arbiter.
// Contents:
//   iic_state_t : arbiter/manager transaction state encoding
//   RNW_BIT     : bit position of the read/not-write flag inside tuser
package axis_iic_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FWD_CMD   = 2'd1,
        WAIT_RESP = 2'd2,
        TIMEOUT   = 2'd3
    } iic_state_t;

    localparam int RNW_BIT = 0;

endpackage

// File: rtl/iic_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at (last+1) mod N_REQ upward with wrap-around and
// reports the first set request.
// Ports:
//   req   in  N_REQ          request vector
//   last  in  $clog2(N_REQ)  index granted most recently
//   valid out 1              at least one request is set
//   idx   out $clog2(N_REQ)  winning index (0 when valid is low)
module iic_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] w_cand;

    // Walk the scan order backwards so the candidate closest to last+1
    // is written last and therefore wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(last) + k) % N_REQ);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/axis_iic_req_arbiter.sv
// Packet-level round-robin arbiter that shares one I2C manager between
// N_REQ AXI-Stream requesters. One requester is granted per transaction;
// its command packet is forwarded to the manager and, for reads, the
// manager's response packet is steered back to it under a beat timeout.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   s_axis_*  (N_REQ slices)     requester command streams
//   m_axis_*                     command stream to the manager
//   s_resp_*                     response stream from the manager
//   m_resp_*                     response to requesters (tvalid/tready one bit each)
//   grant_id                     current/last granted requester
//   busy                         not in IDLE
//   timeout_err                  1-cycle pulse on response timeout
//   drop_pulse                   1-cycle pulse per stray response beat dropped in IDLE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrate; drop any stray response beats
// FWD_CMD   | pass granted requester's command packet to the manager
// WAIT_RESP | pass manager response to granted requester, run timer
// TIMEOUT   | response stalled too long; pulse timeout_err for one cycle
module axis_iic_req_arbiter
    import axis_iic_pkg::*;
#(
    parameter int N_BYTES        = 32,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         resetn,

    input  logic [N_REQ*N_BYTES*8-1:0]   s_axis_tdata,
    input  logic [N_REQ*N_BYTES-1:0]     s_axis_tkeep,
    input  logic [N_REQ*8-1:0]           s_axis_tuser,
    input  logic [N_REQ-1:0]             s_axis_tvalid,
    output logic [N_REQ-1:0]             s_axis_tready,
    input  logic [N_REQ-1:0]             s_axis_tlast,

    output logic [N_BYTES*8-1:0]         m_axis_tdata,
    output logic [N_BYTES-1:0]           m_axis_tkeep,
    output logic [7:0]                   m_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,

    input  logic [N_BYTES*8-1:0]         s_resp_tdata,
    input  logic [N_BYTES-1:0]           s_resp_tkeep,
    input  logic                         s_resp_tvalid,
    output logic                         s_resp_tready,
    input  logic                         s_resp_tlast,

    output logic [N_BYTES*8-1:0]         m_resp_tdata,
    output logic [N_BYTES-1:0]           m_resp_tkeep,
    output logic [N_REQ-1:0]             m_resp_tvalid,
    input  logic [N_REQ-1:0]             m_resp_tready,
    output logic                         m_resp_tlast,

    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy,
    output logic                         timeout_err,
    output logic                         drop_pulse
);

    localparam int DW         = N_BYTES * 8;
    localparam int GW         = $clog2(N_REQ);
    localparam bit TMO_EN     = (TIMEOUT_CYCLES > 0);
    localparam int TW         = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMO_LAST_I = TMO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LAST_I);

    iic_state_t    r_state;
    iic_state_t    w_next;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic          r_rnw;
    logic [TW-1:0] r_timer;
    logic          r_run;

    logic          w_pick_valid;
    logic [GW-1:0] w_pick_idx;
    logic          w_cmd_done;
    logic          w_resp_acc;
    logic          w_tmo_hit;

    logic [DW-1:0]      w_tdata_arr [N_REQ];
    logic [N_BYTES-1:0] w_tkeep_arr [N_REQ];
    logic [7:0]         w_tuser_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign w_tdata_arr[i] = s_axis_tdata[i*DW +: DW];
        assign w_tkeep_arr[i] = s_axis_tkeep[i*N_BYTES +: N_BYTES];
        assign w_tuser_arr[i] = s_axis_tuser[i*8 +: 8];
    end

    iic_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (s_axis_tvalid),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Payload muxes are always live; only valid/ready are state-gated.
    assign m_axis_tdata = w_tdata_arr[r_grant];
    assign m_axis_tkeep = w_tkeep_arr[r_grant];
    assign m_axis_tuser = w_tuser_arr[r_grant];
    assign m_axis_tlast = s_axis_tlast[r_grant];

    assign m_resp_tdata = s_resp_tdata;
    assign m_resp_tkeep = s_resp_tkeep;
    assign m_resp_tlast = s_resp_tlast;

    assign grant_id    = r_grant;
    assign busy        = (r_state != IDLE);
    assign timeout_err = (r_state == TIMEOUT);

    assign w_cmd_done = (r_state == FWD_CMD) & s_axis_tvalid[r_grant]
                        & m_axis_tready & s_axis_tlast[r_grant];
    assign w_resp_acc = (r_state == WAIT_RESP) & s_resp_tvalid & m_resp_tready[r_grant];
    assign w_tmo_hit  = TMO_EN && (r_timer == TMO_LAST);

    always_comb begin
        w_next        = r_state;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_resp_tvalid = '0;
        s_resp_tready = 1'b0;
        drop_pulse    = 1'b0;
        case (r_state)
            IDLE: begin
                // r_run keeps the drop sink closed while reset is asserted.
                s_resp_tready = r_run;
                drop_pulse    = r_run & s_resp_tvalid;
                if (w_pick_valid) begin
                    w_next = FWD_CMD;
                end
            end
            FWD_CMD: begin
                m_axis_tvalid          = s_axis_tvalid[r_grant];
                s_axis_tready[r_grant] = m_axis_tready;
                if (w_cmd_done) begin
                    w_next = r_rnw ? WAIT_RESP : IDLE;
                end
            end
            WAIT_RESP: begin
                m_resp_tvalid[r_grant] = s_resp_tvalid;
                s_resp_tready          = m_resp_tready[r_grant];
                // An accepted beat on the expiry cycle clears the timer, so it wins.
                if (w_resp_acc && s_resp_tlast) begin
                    w_next = IDLE;
                end else if (!w_resp_acc && w_tmo_hit) begin
                    w_next = TIMEOUT;
                end
            end
            TIMEOUT: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(N_REQ - 1);
            r_rnw   <= 1'b0;
            r_timer <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            if (r_state == IDLE && w_pick_valid) begin
                r_grant <= w_pick_idx;
                r_rnw   <= w_tuser_arr[w_pick_idx][RNW_BIT];
            end
            if (w_cmd_done) begin
                r_last <= r_grant;
            end
            if (r_state != WAIT_RESP || w_resp_acc) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_iic_req_arbiter.sv
module tb_axis_iic_req_arbiter;

    localparam int NB  = 2;
    localparam int NR  = 4;
    localparam int TMO = 16;
    localparam int DW  = NB * 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [NR*DW-1:0] s_axis_tdata;
    logic [NR*NB-1:0] s_axis_tkeep;
    logic [NR*8-1:0]  s_axis_tuser;
    logic [NR-1:0]    s_axis_tvalid;
    logic [NR-1:0]    s_axis_tready;
    logic [NR-1:0]    s_axis_tlast;
    logic [DW-1:0]    m_axis_tdata;
    logic [NB-1:0]    m_axis_tkeep;
    logic [7:0]       m_axis_tuser;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic [DW-1:0]    s_resp_tdata;
    logic [NB-1:0]    s_resp_tkeep;
    logic             s_resp_tvalid;
    logic             s_resp_tready;
    logic             s_resp_tlast;
    logic [DW-1:0]    m_resp_tdata;
    logic [NB-1:0]    m_resp_tkeep;
    logic [NR-1:0]    m_resp_tvalid;
    logic [NR-1:0]    m_resp_tready;
    logic             m_resp_tlast;
    logic [1:0]       grant_id;
    logic             busy;
    logic             timeout_err;
    logic             drop_pulse;

    axis_iic_req_arbiter #(
        .N_BYTES(NB), .N_REQ(NR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .s_resp_tdata(s_resp_tdata), .s_resp_tkeep(s_resp_tkeep),
        .s_resp_tvalid(s_resp_tvalid), .s_resp_tready(s_resp_tready),
        .s_resp_tlast(s_resp_tlast),
        .m_resp_tdata(m_resp_tdata), .m_resp_tkeep(m_resp_tkeep),
        .m_resp_tvalid(m_resp_tvalid), .m_resp_tready(m_resp_tready),
        .m_resp_tlast(m_resp_tlast),
        .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .drop_pulse(drop_pulse)
    );

    // Per-requester drive registers, packed onto the DUT buses.
    logic [DW-1:0] rq_data [NR];
    logic [NB-1:0] rq_keep [NR];
    logic [7:0]    rq_user [NR];
    logic [NR-1:0] rq_valid;
    logic [NR-1:0] rq_last;

    always_comb begin
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tuser = '0;
        for (int r = 0; r < NR; r++) begin
            s_axis_tdata[r*DW +: DW] = rq_data[r];
            s_axis_tkeep[r*NB +: NB] = rq_keep[r];
            s_axis_tuser[r*8 +: 8]   = rq_user[r];
        end
    end
    assign s_axis_tvalid = rq_valid;
    assign s_axis_tlast  = rq_last;

    typedef struct packed {
        logic [3:0]    id;
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic [7:0]    user;
        logic          last;
    } axb_t;

    typedef struct packed {
        logic [3:0]    id;
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } rsb_t;

    typedef struct {
        logic [3:0]  mask;
        int          nb;
        logic [15:0] order;
        int          n;
    } arb_vec_t;

    axb_t axq[$];
    rsb_t rsq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic resp_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [NB-1:0] kp(input int b, input int nb);
        return (b == nb - 1) ? 2'b01 : 2'b11;
    endfunction

    function automatic axb_t mk_ax(input int r, input logic [DW-1:0] d, input int b,
                                   input int nb, input logic [7:0] u);
        axb_t x;
        x.id = 4'(r); x.data = d; x.keep = kp(b, nb); x.user = u; x.last = (b == nb - 1);
        return x;
    endfunction

    function automatic logic [7:0] usr(input int r);
        return {7'(16 + r), 1'b0};
    endfunction

    // Scoreboard: command beats seen by the manager.
    always @(negedge clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            axb_t a, e;
            chk("axis_beat_expected", 64'(axq.size() != 0), 64'd1);
            if (axq.size() != 0) begin
                e = axq.pop_front();
                a = {4'(grant_id), m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
                chk("axis_beat", 64'(a), 64'(e));
            end
        end
    end

    // Scoreboard: response beats delivered to a requester.
    always @(negedge clk) begin
        logic [NR-1:0] w;
        w = m_resp_tvalid & m_resp_tready;
        if (resetn && w != '0) begin
            rsb_t a, e;
            int id;
            id = 0;
            for (int r = 0; r < NR; r++) if (w[r]) id = r;
            chk("resp_onehot", 64'($onehot(m_resp_tvalid)), 64'd1);
            chk("resp_beat_expected", 64'(rsq.size() != 0), 64'd1);
            if (rsq.size() != 0) begin
                e = rsq.pop_front();
                a = {4'(id), m_resp_tdata, m_resp_tkeep, m_resp_tlast};
                chk("resp_beat", 64'(a), 64'(e));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the last handshake.
    task automatic send_pkt(input int r, input int nb, input logic [7:0] u, input logic [DW-1:0] base);
        for (int b = 0; b < nb; b++) begin
            int n;
            rq_valid[r] = 1'b1;
            rq_data[r]  = base + DW'(b);
            rq_keep[r]  = kp(b, nb);
            rq_user[r]  = u;
            rq_last[r]  = (b == nb - 1);
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axis_tready[r] && n < 300);
            chk("cmd_accept", 64'(s_axis_tready[r]), 64'd1);
            @(posedge clk); #1;
            if (n >= 300) break;
        end
        rq_valid[r] = 1'b0;
        rq_last[r]  = 1'b0;
    endtask

    task automatic send_resp(input int nb, input logic [DW-1:0] base);
        for (int b = 0; b < nb; b++) begin
            int n;
            s_resp_tvalid = 1'b1;
            s_resp_tdata  = base + DW'(b);
            s_resp_tkeep  = kp(b, nb);
            s_resp_tlast  = (b == nb - 1);
            n = 0;
            do begin @(negedge clk); n++; end while (!s_resp_tready && n < 300);
            chk("resp_accept", 64'(s_resp_tready), 64'd1);
            @(posedge clk); #1;
            if (n >= 300) break;
        end
        s_resp_tvalid = 1'b0;
        s_resp_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    arb_vec_t vec [6];

    initial begin
        int r, first, cnt, bad, n;
        logic [DW-1:0] d;

        // {mask, beats, grant order (nibble 0 first), count}
        vec[0] = '{4'b0010, 1, 16'h0001, 1};
        vec[1] = '{4'b1010, 1, 16'h0013, 2};
        vec[2] = '{4'b1000, 1, 16'h0003, 1};
        vec[3] = '{4'b1111, 2, 16'h3210, 4};
        vec[4] = '{4'b0101, 1, 16'h0020, 2};
        vec[5] = '{4'b0011, 1, 16'h0010, 2};

        for (int i = 0; i < NR; i++) begin
            rq_data[i] = '0; rq_keep[i] = '0; rq_user[i] = '0;
        end
        rq_valid = '0; rq_last = '0;
        m_axis_tready = 1'b1; m_resp_tready = '1;
        s_resp_tdata = '0; s_resp_tkeep = '0; s_resp_tvalid = 1'b0; s_resp_tlast = 1'b0;
        resp_done = 1'b0;
        resetn = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_axis_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_s_resp_tready", 64'(s_resp_tready), 64'd0);
        chk("rst_m_resp_tvalid", 64'(m_resp_tvalid), 64'd0);
        chk("rst_flags", 64'({timeout_err, drop_pulse}), 64'd0);
        resetn = 1'b1;

        // 2-beat write from req0: one idle cycle, then both beats
        axq.push_back(mk_ax(0, 16'hA000, 0, 2, 8'hA0));
        axq.push_back(mk_ax(0, 16'hA001, 1, 2, 8'hA0));
        @(posedge clk); #1;
        fork
            send_pkt(0, 2, 8'hA0, 16'hA000);
            begin
                @(negedge clk);
                chk("wr_idle_ready", 64'(s_axis_tready[0]), 64'd0);
                chk("wr_idle_busy", 64'(busy), 64'd0);
                @(negedge clk);
                chk("wr_fwd_busy", 64'(busy), 64'd1);
            end
        join
        @(negedge clk);
        chk("wr_busy_drop", 64'(busy), 64'd0);

        // Stray response beat in IDLE
        @(posedge clk); #1;
        s_resp_tvalid = 1'b1; s_resp_tdata = 16'h5A5A; s_resp_tlast = 1'b1;
        @(negedge clk);
        chk("drop_pulse_hi", 64'(drop_pulse), 64'd1);
        chk("drop_ready", 64'(s_resp_tready), 64'd1);
        chk("drop_no_tvalid", 64'(m_resp_tvalid), 64'd0);
        @(posedge clk); #1;
        s_resp_tvalid = 1'b0; s_resp_tlast = 1'b0;
        @(negedge clk);
        chk("drop_pulse_lo", 64'(drop_pulse), 64'd0);
        @(posedge clk); #1;

        // Arbitration vectors
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < vec[e].n; i++) begin
                r = int'(vec[e].order[i*4 +: 4]);
                for (int b = 0; b < vec[e].nb; b++) begin
                    d = {4'(e + 1), 4'(r), 8'(b)};
                    axq.push_back(mk_ax(r, d, b, vec[e].nb, usr(r)));
                end
            end
            fork
                begin if (vec[e].mask[0]) send_pkt(0, vec[e].nb, usr(0), {4'(e + 1), 4'd0, 8'd0}); end
                begin if (vec[e].mask[1]) send_pkt(1, vec[e].nb, usr(1), {4'(e + 1), 4'd1, 8'd0}); end
                begin if (vec[e].mask[2]) send_pkt(2, vec[e].nb, usr(2), {4'(e + 1), 4'd2, 8'd0}); end
                begin if (vec[e].mask[3]) send_pkt(3, vec[e].nb, usr(3), {4'(e + 1), 4'd3, 8'd0}); end
            join
        end

        // Read from req2, 3 response beats with toggling ready
        axq.push_back(mk_ax(2, 16'hA100, 0, 1, 8'hA1));
        send_pkt(2, 1, 8'hA1, 16'hA100);
        @(negedge clk);
        chk("rd_wait_busy", 64'(busy), 64'd1);
        for (int b = 0; b < 3; b++) rsq.push_back({4'd2, 16'hD000 + 16'(b), kp(b, 3), (b == 2)});
        @(posedge clk); #1;
        resp_done = 1'b0;
        fork
            begin send_resp(3, 16'hD000); resp_done = 1'b1; end
            begin
                while (!resp_done) begin
                    @(posedge clk); #1;
                    if (!resp_done) m_resp_tready[2] = ~m_resp_tready[2];
                end
            end
        join
        m_resp_tready = '1;
        @(negedge clk);
        chk("rd_idle_after_tlast", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Read from req1 with no response: timeout 16 cycles after entry
        axq.push_back(mk_ax(1, 16'hE000, 0, 1, 8'h43));
        send_pkt(1, 1, 8'h43, 16'hE000);
        first = -1; cnt = 0; bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (timeout_err) begin
                if (first < 0) first = k;
                cnt++;
            end
            if (m_resp_tvalid != '0) bad = 1;
        end
        chk("tmo_cycle", 64'(first), 64'd16);
        chk("tmo_pulse_width", 64'(cnt), 64'd1);
        chk("tmo_no_resp_valid", 64'(bad), 64'd0);
        chk("tmo_back_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Read from req3; final beat lands on the expiry cycle
        axq.push_back(mk_ax(3, 16'hF000, 0, 1, 8'h63));
        send_pkt(3, 1, 8'h63, 16'hF000);
        repeat (15) @(posedge clk);
        #1;
        s_resp_tvalid = 1'b1; s_resp_tdata = 16'hF00D; s_resp_tkeep = 2'b01; s_resp_tlast = 1'b1;
        rsq.push_back({4'd3, 16'hF00D, 2'b01, 1'b1});
        @(negedge clk);
        chk("race_no_tmo", 64'(timeout_err), 64'd0);
        chk("race_ready", 64'(s_resp_tready), 64'd1);
        @(posedge clk); #1;
        s_resp_tvalid = 1'b0; s_resp_tlast = 1'b0;
        @(negedge clk);
        chk("race_idle", 64'(busy), 64'd0);
        chk("race_no_tmo_after", 64'(timeout_err), 64'd0);
        @(posedge clk); #1;

        // Make req0 the last grant, then abandon a 4-beat packet with reset
        axq.push_back(mk_ax(0, 16'hC000, 0, 1, 8'hC0));
        send_pkt(0, 1, 8'hC0, 16'hC000);
        axq.push_back(mk_ax(0, 16'hB000, 0, 4, 8'hB0));
        rq_valid[0] = 1'b1; rq_data[0] = 16'hB000; rq_keep[0] = 2'b11;
        rq_user[0] = 8'hB0; rq_last[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axis_tready[0] && n < 50);
        chk("rst_mid_beat1", 64'(s_axis_tready[0]), 64'd1);
        @(posedge clk); #1;
        rq_data[0] = 16'hB001;
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_mid_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_mid_resp", 64'({s_resp_tready, m_resp_tvalid}), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        rq_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        axq.push_back(mk_ax(0, 16'h9000, 0, 1, usr(0)));
        axq.push_back(mk_ax(1, 16'h9100, 0, 1, usr(1)));
        fork
            send_pkt(0, 1, usr(0), 16'h9000);
            send_pkt(1, 1, usr(1), 16'h9100);
        join
        repeat (2) @(negedge clk);

        chk("axis_queue_drained", 64'(axq.size()), 64'd0);
        chk("resp_queue_drained", 64'(rsq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
